// File: rtl/return_address_stack_pkg.sv
// Shared constants and state encoding for the call/return address stack.
// The control unit and the bench read the state enum from here.
package return_address_stack_pkg;

    localparam int PC_W       = 12;
    localparam int RAS_ADDR_W = PC_W;
    localparam int RAS_DEPTH  = 8;
    localparam int CNT_W      = $clog2(RAS_DEPTH) + 1;

    typedef enum logic [1:0] {
        RAS_EMPTY,
        RAS_PARTIAL,
        RAS_FULL,
        RAS_FAULT
    } ras_state_e;

endpackage

// File: rtl/return_address_stack_storage.sv
// Return-address register array with one synchronous write port and one
// asynchronous read port. Contents are not reset.
module ras_storage #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ADDR_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ADDR_W-1:0]        rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/return_address_stack.sv
// Call/return stack: pointer, occupancy flags and sticky fault flags around
// a register array. top_out is combinational so pop and pc-load share an edge.
//
// state       | meaning
// RAS_EMPTY   | count == 0, no fault recorded
// RAS_PARTIAL | 0 < count < DEPTH, no fault recorded
// RAS_FULL    | count == DEPTH, no fault recorded
// RAS_FAULT   | overflow or underflow seen since last rst/clear
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       fault
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = IDX_W + 1;

    logic [CW-1:0]     count_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              is_empty;
    logic              is_full;
    logic [IDX_W-1:0]  top_idx;
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [ADDR_W-1:0] rdata;

    assign is_empty = (count_r == '0);
    assign is_full  = (count_r == CW'(DEPTH));
    // Wraps to DEPTH-1 when empty; the read is masked off in that case.
    assign top_idx  = count_r[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        we    = 1'b0;
        waddr = count_r[IDX_W-1:0];
        if (!rst && !clear) begin
            if (push && pop && !is_empty) begin
                we    = 1'b1;
                waddr = top_idx;
            end else if (push && !is_full) begin
                we    = 1'b1;
                waddr = count_r[IDX_W-1:0];
            end
        end
    end

    ras_storage #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (top_idx),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (push && pop) begin
            // Replace-top keeps count; from empty it behaves as a plain push.
            if (is_empty) begin
                count_r <= CW'(1);
            end
        end else if (push) begin
            if (is_full) begin
                overflow_r <= 1'b1;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                underflow_r <= 1'b1;
            end else begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    assign top_out   = is_empty ? '0 : rdata;
    assign count     = count_r;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign fault     = overflow_r | underflow_r;

endmodule

// File: tb/tb_return_address_stack.sv
// Bench for return_address_stack: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based stack model.
module tb_return_address_stack;
    import return_address_stack_pkg::*;

    localparam int AW = RAS_ADDR_W;
    localparam int D  = RAS_DEPTH;

    logic          clk = 1'b0;
    logic          rst, push, pop, clear;
    logic [AW-1:0] push_data, top_out;
    logic [CNT_W-1:0] count;
    logic          empty, full, overflow, underflow, fault;
    logic [AW-1:0] pc;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] mq[$];
    bit            m_ovf, m_unf;

    typedef struct {
        logic          p, q, c, r;
        logic [AW-1:0] d;
        int            ecnt;
        int            etop;
        logic          eovf, eunf;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    // Datapath stand-in: pc loads the popped address on the pop edge.
    always @(posedge clk) if (pop && !push) pc <= top_out;

    return_address_stack dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (push_data),
        .top_out   (top_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .fault     (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int ecnt, input int etop,
                           input logic eovf, input logic eunf);
        chk({tag, ".count"}, 32'(count), 32'(ecnt));
        chk({tag, ".top"}, 32'(top_out), 32'(etop));
        chk({tag, ".empty"}, 32'(empty), 32'(ecnt == 0));
        chk({tag, ".full"}, 32'(full), 32'(ecnt == D));
        chk({tag, ".ovf"}, 32'(overflow), 32'(eovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(eunf));
        chk({tag, ".fault"}, 32'(fault), 32'(eovf | eunf));
    endtask

    function automatic void model_step();
        if (rst || clear) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (push && pop) begin
            if (mq.size() > 0) mq[$] = push_data;
            else mq.push_back(push_data);
        end else if (push) begin
            if (mq.size() == D) m_ovf = 1;
            else mq.push_back(push_data);
        end else if (pop) begin
            if (mq.size() == 0) m_unf = 1;
            else void'(mq.pop_back());
        end
    endfunction

    task automatic chk_model(input string tag);
        chk_all(tag, mq.size(), (mq.size() > 0) ? int'(mq[$]) : 0, m_ovf, m_unf);
    endtask

    task automatic drive(input logic p, input logic q, input logic c, input logic r,
                         input logic [AW-1:0] d);
        @(negedge clk);
        push = p; pop = q; clear = c; rst = r; push_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic step(input logic p, input logic q, input logic c, input logic r,
                        input logic [AW-1:0] d);
        drive(p, q, c, r, d);
        tick();
    endtask

    function automatic void add(input logic p, input logic q, input logic c,
                                input logic [AW-1:0] d, input int ecnt, input int etop,
                                input logic eovf, input logic eunf);
        vec_t v;
        v.p = p; v.q = q; v.c = c; v.r = 1'b0; v.d = d;
        v.ecnt = ecnt; v.etop = etop; v.eovf = eovf; v.eunf = eunf;
        tbl.push_back(v);
    endfunction

    initial begin
        push = 0; pop = 0; clear = 0; rst = 1; push_data = '0;
        // Directed table: basic push/pop, underflow, clear, fill to overflow.
        add(1, 0, 0, 12'h005, 1, 'h005, 0, 0);
        add(1, 0, 0, 12'h010, 2, 'h010, 0, 0);
        add(1, 0, 0, 12'h0A3, 3, 'h0A3, 0, 0);
        add(0, 1, 0, 12'h000, 2, 'h010, 0, 0);
        add(0, 1, 0, 12'h000, 1, 'h005, 0, 0);
        add(0, 1, 0, 12'h000, 0, 'h000, 0, 0);
        add(0, 1, 0, 12'h000, 0, 'h000, 0, 1);
        add(1, 0, 0, 12'h042, 1, 'h042, 0, 1);
        add(0, 0, 1, 12'h000, 0, 'h000, 0, 0);
        for (int i = 0; i < D; i++) add(1, 0, 0, 12'(12'h100 + i), i + 1, 'h100 + i, 0, 0);
        add(1, 0, 0, 12'hFFF, 8, 'h107, 1, 0);
        add(0, 1, 0, 12'h000, 7, 'h106, 1, 0);
        add(0, 0, 1, 12'h000, 0, 'h000, 0, 0);

        step(0, 0, 0, 1, '0);
        step(0, 0, 0, 1, '0);
        chk_all("reset", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].p, tbl[i].q, tbl[i].c, tbl[i].r, tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].ecnt, tbl[i].etop, tbl[i].eovf, tbl[i].eunf);
        end

        // Replace-top: popped value visible before the edge, new top after.
        step(1, 0, 0, 0, 12'h010);
        step(1, 0, 0, 0, 12'h020);
        drive(1, 1, 0, 0, 12'h033);
        #1 chk("swap.pre_top", 32'(top_out), 32'h020);
        tick();
        chk_all("swap", 2, 'h033, 0, 0);
        step(0, 0, 1, 0, '0);
        step(1, 1, 0, 0, 12'h011);
        chk_all("swap_empty", 1, 'h011, 0, 0);

        // Clear beats push; rst beats push.
        step(0, 0, 1, 0, '0);
        for (int i = 0; i < D; i++) step(1, 0, 0, 0, 12'(12'h200 + i));
        step(1, 0, 0, 0, 12'hABC);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
        chk_all("pre_clr", 5, 'h204, 1, 0);
        step(1, 0, 1, 0, 12'h555);
        chk_all("clr_push", 0, 0, 0, 0);
        step(1, 0, 0, 0, 12'h066);
        step(1, 0, 0, 1, 12'h777);
        chk_all("rst_push", 0, 0, 0, 0);

        // Zero-latency pop into pc.
        step(1, 0, 0, 0, 12'h7FE);
        step(0, 1, 0, 0, '0);
        chk("zl.pc", 32'(pc), 32'h7FE);
        chk_all("zl", 0, 0, 0, 0);

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            int r;
            logic p, q, c, rr;
            r  = $urandom_range(0, 99);
            rr = (r < 1);
            c  = (r >= 1 && r < 4);
            p  = ($urandom_range(0, 99) < 55);
            q  = ($urandom_range(0, 99) < 50);
            step(p, q, c, rr, 12'($urandom));
            chk_model($sformatf("rnd%0d", n));
        end

        drive(0, 0, 0, 0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
Hardware call/return stack that services the datapath's push/pop requests on CALL/RET instructions.
- On push it stores the return address (pc+1) supplied by the datapath.
- On pop it supplies the saved address, which the datapath loads into pc on the same clock edge.
- It also tracks occupancy and flags overflow and underflow so the control unit can halt on stack faults.

Parameters:
ADDR_W, 12, width of a stored return address (matches pc width)
DEPTH, 8, number of entries; must be a power of two, at least 2

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous active-high reset
push  input  1  store push_data as the new top of stack
pop  input  1  remove the top entry
clear  input  1  synchronous flush: empty the stack and clear the fault flags
push_data  input  ADDR_W  return address to store
top_out  output  ADDR_W  current top entry, combinational from stored state
count  output  $clog2(DEPTH)+1  number of valid entries
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky: a push was attempted while full
underflow  output  1  sticky: a pop was attempted while empty
fault  output  1  overflow|underflow

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: count=0, empty=1, full=0, overflow=0, underflow=0, fault=0. top_out=0 while empty. Entry contents are don't-care and need no reset.
- top_out = mem[count-1] when count>0, else 0. Valid before the clock edge, so the datapath can pop and load pc in the same cycle (zero-latency read).
- Storage: a DEPTH-entry register array indexed by stack pointer sp = count. No wrap-around; sp saturates at 0 and DEPTH.
- State machine, encoded in count plus the fault flag: EMPTY, PARTIAL, FULL, FAULT.
  - EMPTY: push -> PARTIAL (FULL if DEPTH==1 is illegal); pop -> FAULT (underflow=1).
  - PARTIAL: push -> PARTIAL, or FULL when count reaches DEPTH; pop -> PARTIAL, or EMPTY when count reaches 0.
  - FULL: pop -> PARTIAL; push -> FAULT (overflow=1, no write, count unchanged).
  - FAULT: flags are sticky. Push/pop still operate within bounds, and out-of-bounds requests are still ignored. Only rst or clear leaves FAULT.
- Push only, with count<DEPTH: mem[count]<=push_data; count<=count+1.
- Pop only, with count>0: count<=count-1. Memory is untouched.
- Simultaneous push and pop:
  - count>0: replace the top, mem[count-1]<=push_data, count unchanged. The pre-edge top_out is the popped value.
  - count==0: treat as push only; underflow is not set.
- clear: count<=0, overflow<=0, underflow<=0. Clear has priority over push/pop in the same cycle. rst has priority over clear.
- Arithmetic: count is unsigned. Overflow/underflow decisions use the pre-edge count only.

Decomposition:
- Shared package holds:
  - constant RAS_ADDR_W=12 (tied to PC_W);
  - constant RAS_DEPTH=8;
  - localparam CNT_W=$clog2(RAS_DEPTH)+1;
  - state enum {RAS_EMPTY, RAS_PARTIAL, RAS_FULL, RAS_FAULT}, exported for the control unit and the bench.
- One natural sub-module: ras_storage, the DEPTH x ADDR_W register array with one write port and one async read port. Pointer, flags and FSM stay in the top.

Test Plan:
- Reset, then push 0x005, 0x010, 0x0A3 -> count=3, top_out=0x0A3. Then pop x3 -> top_out sequence 0x0A3, 0x010, 0x005; finally empty=1, top_out=0.
- Push 8 values 0x100..0x107 -> full=1 after the 8th. A 9th push of 0xFFF -> overflow=1, fault=1, count=8, top_out=0x107. Then pop -> top_out=0x106, overflow stays 1.
- From empty, pop -> underflow=1, count=0. Then push 0x042 -> count=1, top_out=0x042, underflow still 1. Then clear -> all flags 0, empty=1.
- With count=2 and top 0x020, assert push (0x033) and pop together -> pre-edge top_out=0x020, post-edge count=2, top_out=0x033. From empty with push+pop of 0x011 -> count=1, top_out=0x011, underflow=0.
- With count=5 and overflow=1, assert clear and push together -> count=0, overflow=0, no write. Then assert rst with push -> count=0, empty=1.
- Zero-latency check: with count=1 and top 0x7FE, pulse pop, and a model datapath samples top_out into pc on the same edge -> pc=0x7FE, count=0.
